// File: rtl/uart_tx_slave_pkg.sv
// Shared register map, bit positions and transmitter state encoding for the UART TX slave.
package uart_tx_slave_pkg;

  localparam logic [4:0] AddrCr = 5'h00;
  localparam logic [4:0] AddrDr = 5'h04;
  localparam logic [4:0] AddrBr = 5'h08;
  localparam logic [4:0] AddrSr = 5'h0C;

  localparam int unsigned CrTxEn    = 0;
  localparam int unsigned CrFifoClr = 1;

  localparam int unsigned SrBusy  = 0;
  localparam int unsigned SrFull  = 1;
  localparam int unsigned SrEmpty = 2;
  localparam int unsigned SrOvf   = 3;
  localparam int unsigned SrLevel = 8;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

  // A divider of zero still yields a one-cycle bit.
  function automatic logic [15:0] bit_period(input logic [15:0] br);
    return (br == 16'd0) ? 16'd1 : br;
  endfunction

endpackage

// File: rtl/uart_tx_slave_if.sv
// Simple register bus between a bus master and the UART TX slave.
interface uart_tx_slave_if;
  logic [4:0]  addr;
  logic        re;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output addr, re, we, wd, input rd);
  modport slave  (input addr, re, we, wd, output rd);
endinterface

// File: rtl/uart_tx_slave_fifo.sv
// Byte FIFO with extra-bit pointer wrap; clear has priority over push and pop.
module uart_tx_slave_fifo #(
  parameter int unsigned Depth = 8,
  localparam int unsigned Aw = $clog2(Depth)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [Aw:0]   level
);

  logic [7:0]  mem_q [Depth];
  logic [Aw:0] wr_ptr_q, rd_ptr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_ptr_q[Aw-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q[Aw-1:0]];
  assign level = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (level == (Aw+1)'(Depth));

endmodule

// File: rtl/uart_tx_slave.sv
// Register-mapped 8N1 UART transmitter: bus decode, control registers, FIFO and bit FSM.
module uart_tx_slave
  import uart_tx_slave_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic             clk,
  input  logic             rstn,
  uart_tx_slave_if.slave   bus,
  output logic             uart_tx
);

  localparam int unsigned Lw = $clog2(FIFO_DEPTH) + 1;

  logic [4:0]  word;
  logic        wr_cr, wr_dr, wr_br, wr_sr, fifo_clr;
  logic        tx_en_q, ovf_q, ovf_set;
  logic [15:0] br_q;
  logic        push, pop, full, empty, start_ok, bit_done;
  logic [7:0]  fifo_rdata;
  logic [Lw-1:0] level;
  logic [31:0] rd_data;

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d, div_q, div_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;

  logic unused_bits;
  assign unused_bits = ^{bus.addr[1:0], bus.wd[31:16]};

  assign word     = {bus.addr[4:2], 2'b00};
  assign wr_cr    = bus.we && (word == AddrCr);
  assign wr_dr    = bus.we && (word == AddrDr);
  assign wr_br    = bus.we && (word == AddrBr);
  assign wr_sr    = bus.we && (word == AddrSr);
  assign fifo_clr = wr_cr && bus.wd[CrFifoClr];

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push    = wr_dr && (!full || pop);
  assign ovf_set = wr_dr && full && !pop;

  uart_tx_slave_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (fifo_clr),
    .push  (push),
    .pop   (pop),
    .wdata (bus.wd[7:0]),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_en_q <= 1'b0;
      br_q    <= DEFAULT_DIV;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_cr) tx_en_q <= bus.wd[CrTxEn];
      if (wr_br) br_q <= bus.wd[15:0];
      if (ovf_set) ovf_q <= 1'b1;
      else if (wr_sr && bus.wd[SrOvf]) ovf_q <= 1'b0;
    end
  end

  assign start_ok = tx_en_q && !empty && !fifo_clr;
  assign bit_done = (cnt_q == 16'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      div_q     <= 16'd1;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          pop     = 1'b1;
          state_d = StStart;
          shift_d = fifo_rdata;
          div_d   = bit_period(br_q);
          cnt_d   = bit_period(br_q) - 16'd1;
        end
      end
      StStart: begin
        if (bit_done) begin
          state_d   = StData;
          cnt_d     = div_q - 16'd1;
          bit_idx_d = '0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StData: begin
        if (bit_done) begin
          cnt_d     = div_q - 16'd1;
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StStop: begin
        if (bit_done) begin
          if (start_ok) begin
            pop     = 1'b1;
            state_d = StStart;
            shift_d = fifo_rdata;
            div_d   = bit_period(br_q);
            cnt_d   = bit_period(br_q) - 16'd1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    uart_tx = 1'b1;
    unique case (state_q)
      StStart: uart_tx = 1'b0;
      StData:  uart_tx = shift_q[0];
      default: uart_tx = 1'b1;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (bus.re) begin
      unique case (word)
        AddrCr: rd_data[CrTxEn] = tx_en_q;
        AddrBr: rd_data[15:0] = br_q;
        AddrSr: begin
          rd_data[SrBusy]       = (state_q != StIdle);
          rd_data[SrFull]       = full;
          rd_data[SrEmpty]      = empty;
          rd_data[SrOvf]        = ovf_q;
          rd_data[SrLevel +: Lw] = level;
        end
        default: rd_data = '0;
      endcase
    end
  end

  assign bus.rd = rd_data;

endmodule

// File: tb/tb_uart_tx_slave.sv
// Self-checking bench for uart_tx_slave: expected line waveforms come from 8N1 framing arithmetic.
module tb_uart_tx_slave;

  localparam logic [4:0] ACR = 5'h00;
  localparam logic [4:0] ADR = 5'h04;
  localparam logic [4:0] ABR = 5'h08;
  localparam logic [4:0] ASR = 5'h0C;

  logic clk;
  logic rstn;
  logic uart_tx;
  int   n_checks;
  int   n_fail;

  uart_tx_slave_if bus ();

  uart_tx_slave #(
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd434)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus),
    .uart_tx (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.we = 1'b1; bus.addr = a; bus.wd = d;
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.re = 1'b1; bus.addr = a;
    #1 d = bus.rd;
    bus.re = 1'b0;
  endtask

  // Watch whole frames cycle by cycle starting right after the triggering write; an optional
  // CR write is injected at cycle inj (negative disables it).
  task automatic run_frames(input logic [7:0] bytes [$], input int div, input string name,
                            input int inj, input logic [31:0] inj_wd);
    int total;
    int f;
    int p;
    logic exp_bit;
    total = bytes.size() * 10 * div;
    #1;
    n_checks++;
    if (uart_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL %s pre-start line: got %b want 1", name, uart_tx);
    end
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      if (i == inj) begin
        bus.re = 1'b0; bus.we = 1'b1; bus.addr = ACR; bus.wd = inj_wd;
      end else begin
        bus.re = 1'b1; bus.we = 1'b0; bus.addr = ASR;
      end
      #1;
      f = i / (10 * div);
      p = (i % (10 * div)) / div;
      exp_bit = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : bytes[f][p-1];
      n_checks++;
      if (uart_tx !== exp_bit) begin
        n_fail++;
        $display("FAIL %s line cycle %0d: got %b want %b", name, i, uart_tx, exp_bit);
      end
      if (i != inj) begin
        n_checks++;
        if (bus.rd[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL %s busy cycle %0d: got %b want 1", name, i, bus.rd[0]);
        end
      end
    end
    @(negedge clk);
    bus.we = 1'b0; bus.re = 1'b1; bus.addr = ASR;
    #1;
    n_checks++;
    if (uart_tx !== 1'b1 || bus.rd[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s post-frame idle: got tx=%b busy=%b want tx=1 busy=0",
               name, uart_tx, bus.rd[0]);
    end
    bus.re = 1'b0;
  endtask

  task automatic check_reg(input logic [4:0] a, input logic [31:0] exp, input string name);
    logic [31:0] d;
    bus_read(a, d);
    n_checks++;
    if (d !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h", name, d, exp);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (bus.rd !== 32'h0 || uart_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL reset outputs: got rd=%08h tx=%b want rd=0 tx=1", bus.rd, uart_tx);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    check_reg(ACR, 32'h0, "reset CR");
    check_reg(ABR, 32'd434, "reset BR");
    check_reg(ASR, 32'h4, "reset SR");
    check_reg(ADR, 32'h0, "DR reads zero");
    check_reg(5'h10, 32'h0, "unmapped reads zero");
  endtask

  task automatic test_rw_collision;
    @(negedge clk);
    bus.re = 1'b1; bus.we = 1'b1; bus.addr = ABR; bus.wd = 32'h0000_0007;
    #1;
    n_checks++;
    if (bus.rd !== 32'd434) begin
      n_fail++;
      $display("FAIL re/we collision: got %08h want %08h", bus.rd, 32'd434);
    end
    @(negedge clk);
    bus.re = 1'b0; bus.we = 1'b0;
    check_reg(ABR, 32'h7, "BR after collision write");
  endtask

  task automatic test_single_frame;
    logic [7:0] q [$];
    q = '{8'hA5};
    bus_write(ABR, 32'd4);
    bus_write(ACR, 32'h1);
    bus_write(ADR, 32'hA5);
    run_frames(q, 4, "single A5", -1, 32'h0);
    bus_write(ACR, 32'h0);
  endtask

  task automatic test_overflow;
    logic [7:0] q [$];
    logic [7:0] b;
    q = {};
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      if (i < 8) q.push_back(b);
      bus_write(ADR, {24'h0, b});
    end
    check_reg(ASR, 32'h0000_080A, "SR full+ovf");
    bus_write(ASR, 32'h8);
    check_reg(ASR, 32'h0000_0802, "SR after ovf clear");
    bus_write(ABR, 32'd2);
    bus_write(ACR, 32'h1);
    run_frames(q, 2, "drain full fifo", -1, 32'h0);
    check_reg(ASR, 32'h4, "SR after drain");
    bus_write(ACR, 32'h0);
  endtask

  task automatic test_back_to_back;
    logic [7:0] q [$];
    q = {};
    for (int i = 0; i < 3; i++) begin
      q.push_back(8'($urandom));
      bus_write(ADR, {24'h0, q[i]});
    end
    bus_write(ABR, 32'd2);
    bus_write(ACR, 32'h1);
    run_frames(q, 2, "back to back", -1, 32'h0);
    check_reg(ASR, 32'h4, "SR empty after burst");
    bus_write(ACR, 32'h0);
  endtask

  task automatic test_clear_mid_frame;
    logic [7:0] q [$];
    q = {};
    for (int i = 0; i < 5; i++) begin
      q.push_back(8'($urandom));
      bus_write(ADR, {24'h0, q[i]});
    end
    bus_write(ABR, 32'd4);
    check_reg(ASR, 32'h0000_0500, "SR level 5 queued");
    bus_write(ACR, 32'h1);
    q = '{q[0]};
    run_frames(q, 4, "clear mid frame", 15, 32'h2);
    check_reg(ASR, 32'h4, "SR after mid-frame clear");
    check_reg(ACR, 32'h0, "CR after mid-frame clear");
    repeat (10) @(negedge clk);
    n_checks++;
    if (uart_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL no frame after clear: got %b want 1", uart_tx);
    end
  endtask

  task automatic test_random;
    logic [7:0] q [$];
    int br;
    int n;
    for (int it = 0; it < 5; it++) begin
      br = (it == 0) ? 0 : int'($urandom_range(1, 3));
      n = int'($urandom_range(1, 4));
      q = {};
      for (int i = 0; i < n; i++) begin
        q.push_back(8'($urandom));
        bus_write(ADR, {24'h0, q[i]});
      end
      bus_write(ABR, br);
      bus_write(ACR, 32'h1);
      run_frames(q, (br == 0) ? 1 : br, "random burst", -1, 32'h0);
      bus_write(ACR, 32'h0);
    end
  endtask

  task automatic test_reset_mid_frame;
    bus_write(ABR, 32'd4);
    bus_write(ADR, 32'h00);
    bus_write(ADR, 32'h3C);
    bus_write(ACR, 32'h1);
    repeat (12) @(negedge clk);
    #1;
    n_checks++;
    if (uart_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL data bit before reset: got %b want 0", uart_tx);
    end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if (uart_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL line on async reset: got %b want 1", uart_tx);
    end
    check_reg(ACR, 32'h0, "CR in reset");
    check_reg(ABR, 32'd434, "BR in reset");
    check_reg(ASR, 32'h4, "SR in reset");
    @(negedge clk);
    rstn = 1'b1;
    check_reg(ASR, 32'h4, "SR after reset release");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.addr = '0; bus.re = 1'b0; bus.we = 1'b0; bus.wd = '0;
    test_reset();
    test_rw_collision();
    test_single_frame();
    test_overflow();
    test_back_to_back();
    test_clear_mid_frame();
    test_random();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
